sprite_overlay_streamer: RTL and testbench

- Parametrised pixel source for the ILI9341 SPI controller path. It generalises the fixed-image, hard-coded-patch streamer.
- Streams an H_RES x V_RES frame from an external base-image memory. Up to NUM_OVL rectangular sprites, each enabled by a status bit, are composited over it at runtime-programmable positions.
- Supports one-shot or continuous frames, with a valid/ready output handshake towards the controller.

---
 rtl/ovl_pkg.sv | 34 +++
 rtl/ovl_hit_sel.sv | 75 +++++++
 rtl/sprite_overlay_streamer.sv | 199 +++++++++++++++++++
 tb/tb_sprite_overlay_streamer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ovl_pkg.sv
// ---------------------------------------------------------------------------
// ovl_pkg
// Shared definitions for the sprite overlay streamer:
//   - TRANSP_DEFAULT : default RGB565 colour key (magenta) for sprite pixels
//   - addr_width     : width of a linear address into an h*v array
//   - coord_width    : width of a coordinate / offset into a dimension of n
//   - idx_width      : width of an overlay index for n overlays
//   - state_t        : streamer FSM states
// ---------------------------------------------------------------------------
package ovl_pkg;

  localparam logic [15:0] TRANSP_DEFAULT = 16'hF81F;

  // A zero-width vector is illegal, so every width helper clamps to 1 bit.
  function automatic int addr_width(input int h, input int v);
    return (h * v > 1) ? $clog2(h * v) : 1;
  endfunction

  function automatic int coord_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/ovl_hit_sel.sv
// ---------------------------------------------------------------------------
// ovl_hit_sel
// Combinational hit test for a pixel coordinate against NUM_OVL sprites.
// Picks the lowest-index enabled sprite covering (x, y) and reports where
// inside that sprite the pixel falls.
// Ports:
//   x, y      : pixel coordinate being tested
//   en        : per-overlay enable
//   ox, oy    : packed per-overlay left column / top row
//   hit       : some enabled overlay covers (x, y)
//   idx       : index of the winning overlay
//   row, col  : pixel offset inside the winning sprite
// ---------------------------------------------------------------------------
module ovl_hit_sel
  import ovl_pkg::*;
#(
  parameter int H_RES   = 128,
  parameter int V_RES   = 128,
  parameter int NUM_OVL = 4,
  parameter int OVL_W   = 8,
  parameter int OVL_H   = 8,
  localparam int XW     = coord_width(H_RES),
  localparam int YW     = coord_width(V_RES),
  localparam int IW     = idx_width(NUM_OVL),
  localparam int CW     = coord_width(OVL_W),
  localparam int RW     = coord_width(OVL_H)
) (
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  logic [NUM_OVL-1:0]    en,
  input  logic [NUM_OVL*XW-1:0] ox,
  input  logic [NUM_OVL*YW-1:0] oy,
  output logic                  hit,
  output logic [IW-1:0]         idx,
  output logic [RW-1:0]         row,
  output logic [CW-1:0]         col
);

  logic [NUM_OVL-1:0] in_rect;
  logic [CW-1:0]      col_i [NUM_OVL];
  logic [RW-1:0]      row_i [NUM_OVL];

  // Rectangle compares use one extra bit so ox+OVL_W past the right edge
  // does not wrap to a small value; sprites clip instead of reappearing
  // in column 0 / row 0.
  for (genvar i = 0; i < NUM_OVL; i++) begin : g_cmp
    logic [XW:0] ox_w;
    logic [YW:0] oy_w;
    assign ox_w = {1'b0, ox[i*XW +: XW]};
    assign oy_w = {1'b0, oy[i*YW +: YW]};
    assign in_rect[i] = en[i]
                      && ({1'b0, x} >= ox_w) && ({1'b0, x} < ox_w + (XW+1)'(OVL_W))
                      && ({1'b0, y} >= oy_w) && ({1'b0, y} < oy_w + (YW+1)'(OVL_H));
    assign col_i[i] = CW'(x - ox[i*XW +: XW]);
    assign row_i[i] = RW'(y - oy[i*YW +: YW]);
  end

  // Scanning from the highest index down lets the lowest hitting index
  // overwrite the others, giving overlay 0 top priority.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    row = '0;
    col = '0;
    for (int i = NUM_OVL - 1; i >= 0; i--) begin
      if (in_rect[i]) begin
        hit = 1'b1;
        idx = IW'(i);
        row = row_i[i];
        col = col_i[i];
      end
    end
  end

endmodule

// File: rtl/sprite_overlay_streamer.sv
// ---------------------------------------------------------------------------
// sprite_overlay_streamer
// Streams an H_RES x V_RES frame from a base-image memory with up to NUM_OVL
// colour-keyed sprites composited on top, one pixel per valid/ready beat.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   frame_start       : start a frame (honoured only when idle)
//   auto_restart      : chain straight into the next frame after the last pixel
//   ovl_en/x/y        : overlay enables and packed positions (sampled per frame)
//   base_addr/rdata   : base image memory, 1-cycle read latency
//   spr_addr/rdata    : sprite memory {idx,row,col}, 1-cycle read latency
//   pix_data/valid    : composited pixel towards the display controller
//   pix_ready         : controller accepts the pixel
//   frame_done        : pulses in the cycle the last pixel is accepted
//   busy              : streamer is not idle
// ---------------------------------------------------------------------------
module sprite_overlay_streamer
  import ovl_pkg::*;
#(
  parameter int H_RES      = 128,
  parameter int V_RES      = 128,
  parameter int PIXEL_SIZE = 16,
  parameter int NUM_OVL    = 4,
  parameter int OVL_W      = 8,
  parameter int OVL_H      = 8,
  parameter logic [PIXEL_SIZE-1:0] TRANSP = PIXEL_SIZE'(TRANSP_DEFAULT),
  localparam int XW  = coord_width(H_RES),
  localparam int YW  = coord_width(V_RES),
  localparam int AW  = addr_width(H_RES, V_RES),
  localparam int SAW = addr_width(NUM_OVL * OVL_W, OVL_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  auto_restart,
  input  logic [NUM_OVL-1:0]    ovl_en,
  input  logic [NUM_OVL*XW-1:0] ovl_x,
  input  logic [NUM_OVL*YW-1:0] ovl_y,
  output logic [AW-1:0]         base_addr,
  input  logic [PIXEL_SIZE-1:0] base_rdata,
  output logic [SAW-1:0]        spr_addr,
  input  logic [PIXEL_SIZE-1:0] spr_rdata,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int IW = idx_width(NUM_OVL);
  localparam int CW = coord_width(OVL_W);
  localparam int RW = coord_width(OVL_H);

  state_t                state, state_next;
  logic [XW-1:0]         x, x_next;
  logic [YW-1:0]         y, y_next;
  logic [AW-1:0]         addr_next;
  logic [NUM_OVL-1:0]    sh_en, sh_en_next;
  logic [NUM_OVL*XW-1:0] sh_x, sh_x_next;
  logic [NUM_OVL*YW-1:0] sh_y, sh_y_next;
  logic                  hit_q;
  logic                  accept;
  logic                  last_pix;
  logic                  sel_hit;
  logic [IW-1:0]         sel_idx;
  logic [RW-1:0]         sel_row;
  logic [CW-1:0]         sel_col;
  logic [SAW-1:0]        spr_addr_next;

  assign accept     = pix_valid && pix_ready;
  assign last_pix   = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));
  assign frame_done = (state == HOLD) && accept && last_pix;
  assign busy       = (state != IDLE);

  // The hit test looks at the coordinate and shadow registers that are about
  // to be loaded, so spr_addr is already registered and stable during FETCH
  // alongside base_addr; both memories then answer in WAIT.
  ovl_hit_sel #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .NUM_OVL(NUM_OVL),
    .OVL_W  (OVL_W),
    .OVL_H  (OVL_H)
  ) u_hit_sel (
    .x  (x_next),
    .y  (y_next),
    .en (sh_en_next),
    .ox (sh_x_next),
    .oy (sh_y_next),
    .hit(sel_hit),
    .idx(sel_idx),
    .row(sel_row),
    .col(sel_col)
  );

  // Multiplication by powers of two reduces to {idx, row, col}.
  assign spr_addr_next = SAW'((int'(sel_idx) * OVL_H + int'(sel_row)) * OVL_W + int'(sel_col));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the pixel walk. base_addr is kept as a linear
  // counter that steps with x so no y*H_RES multiplier is needed. Overlay
  // inputs are copied into shadows only when a frame begins, which keeps a
  // frame tear-free while software moves sprites.
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    addr_next  = base_addr;
    sh_en_next = sh_en;
    sh_x_next  = sh_x;
    sh_y_next  = sh_y;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_next = FETCH;
          x_next     = '0;
          y_next     = '0;
          addr_next  = '0;
          sh_en_next = ovl_en;
          sh_x_next  = ovl_x;
          sh_y_next  = ovl_y;
        end
      end
      FETCH: state_next = WAIT;
      WAIT:  state_next = HOLD;
      HOLD: begin
        if (accept) begin
          if (last_pix) begin
            x_next    = '0;
            y_next    = '0;
            addr_next = '0;
            if (auto_restart) begin
              state_next = FETCH;
              sh_en_next = ovl_en;
              sh_x_next  = ovl_x;
              sh_y_next  = ovl_y;
            end else begin
              state_next = IDLE;
            end
          end else begin
            state_next = FETCH;
            addr_next  = base_addr + AW'(1);
            if (x == XW'(H_RES - 1)) begin
              x_next = '0;
              y_next = y + YW'(1);
            end else begin
              x_next = x + XW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. The sprite address and hit flag only change on
  // entry to FETCH; the composited pixel is captured in WAIT when both
  // memories have answered, and stays put in HOLD until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      base_addr <= '0;
      sh_en     <= '0;
      sh_x      <= '0;
      sh_y      <= '0;
      hit_q     <= 1'b0;
      spr_addr  <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      x         <= x_next;
      y         <= y_next;
      base_addr <= addr_next;
      sh_en     <= sh_en_next;
      sh_x      <= sh_x_next;
      sh_y      <= sh_y_next;
      if (state_next == FETCH) begin
        hit_q    <= sel_hit;
        spr_addr <= spr_addr_next;
      end
      if (state == WAIT) begin
        pix_data  <= (hit_q && (spr_rdata != TRANSP)) ? spr_rdata : base_rdata;
        pix_valid <= 1'b1;
      end else if ((state == HOLD) && accept) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_overlay_streamer.sv
// ---------------------------------------------------------------------------
// tb_sprite_overlay_streamer
// Small 4x4 frame, two 2x2 sprites. Base memory returns its own address.
// Expected pixels come from a per-frame picture computed from the overlay
// rules; a negedge process compares every valid pixel against it.
// ---------------------------------------------------------------------------
module tb_sprite_overlay_streamer;

  localparam int H_RES = 4;
  localparam int V_RES = 4;
  localparam int NUM_OVL = 2;
  localparam int OVL_W = 2;
  localparam int OVL_H = 2;
  localparam int NPIX = H_RES * V_RES;
  localparam logic [15:0] TRANSP = 16'hF81F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        auto_restart = 1'b0;
  logic        pix_ready = 1'b1;
  logic [1:0]  ovl_en = '0;
  logic [3:0]  ovl_x = '0;
  logic [3:0]  ovl_y = '0;
  logic [3:0]  base_addr;
  logic [15:0] base_rdata;
  logic [2:0]  spr_addr;
  logic [15:0] spr_rdata;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_done;
  logic        busy;

  logic [15:0] spr_mem [0:7];

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  bit          m_idle = 1'b1;
  logic [15:0] exp_q[$];
  int          acc_cnt = 0;
  int          cyc = 0;
  int          exp_rise = -100;
  bit          prev_valid = 1'b0;
  bit          prev_accept = 1'b0;
  bit          prev_rst = 1'b0;
  logic [15:0] prev_data = '0;
  int          frame_no = 0;
  int          fd_cnt = 0;
  logic [15:0] frame_log [0:7][0:15];

  sprite_overlay_streamer #(
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .PIXEL_SIZE(16),
    .NUM_OVL   (NUM_OVL),
    .OVL_W     (OVL_W),
    .OVL_H     (OVL_H),
    .TRANSP    (TRANSP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .auto_restart(auto_restart),
    .ovl_en      (ovl_en),
    .ovl_x       (ovl_x),
    .ovl_y       (ovl_y),
    .base_addr   (base_addr),
    .base_rdata  (base_rdata),
    .spr_addr    (spr_addr),
    .spr_rdata   (spr_rdata),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: base image holds its own address, sprites from spr_mem.
  always @(posedge clk) begin
    base_rdata <= {12'h000, base_addr};
    spr_rdata  <= spr_mem[spr_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic ar, input logic [1:0] en, input logic [3:0] ox, input logic [3:0] oy);
    auto_restart = ar;
    ovl_en = en;
    ovl_x = ox;
    ovl_y = oy;
  endtask

  // Whole-frame picture: each pixel shows the first enabled sprite covering
  // it, unless that sprite's texel is the colour key, in which case base.
  task automatic buildFrame(input logic [1:0] en, input logic [3:0] ox, input logic [3:0] oy);
    for (int p = 0; p < NPIX; p++) begin
      int px, py, sx, sy, a;
      logic [15:0] v;
      bit done;
      px = p % H_RES;
      py = p / H_RES;
      v = 16'(p);
      done = 1'b0;
      for (int i = 0; i < NUM_OVL; i++) begin
        sx = int'(ox[i*2 +: 2]);
        sy = int'(oy[i*2 +: 2]);
        if (!done && en[i] && px >= sx && px < sx + OVL_W && py >= sy && py < sy + OVL_H) begin
          done = 1'b1;
          a = i * OVL_W * OVL_H + (py - sy) * OVL_W + (px - sx);
          if (spr_mem[a] != TRANSP) v = spr_mem[a];
        end
      end
      exp_q.push_back(v);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit idle_before, acc, last;
    cyc++;
    idle_before = m_idle;
    acc = pix_valid && pix_ready;
    if (rst) begin
      exp_q.delete();
      m_idle = 1'b1;
      acc_cnt = 0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        checkOutput("post_reset_pix_valid", pix_valid, 0);
        checkOutput("post_reset_busy", busy, 0);
      end
      checkOutput("busy", busy, !idle_before);
      if (pix_valid) begin
        if (exp_q.size() == 0) checkOutput("pix_valid_with_no_pixel_due", pix_valid, 0);
        else checkOutput("pix_data", pix_data, exp_q[0]);
        if (!prev_valid) checkOutput("pixel_cadence_cycle", cyc, exp_rise);
      end
      if (prev_valid && !prev_accept) begin
        checkOutput("hold_pix_valid", pix_valid, 1);
        checkOutput("hold_pix_data", pix_data, prev_data);
      end
      last = acc && (acc_cnt == NPIX - 1);
      checkOutput("frame_done", frame_done, last);
      if (frame_done) fd_cnt++;
      if (acc && exp_q.size() > 0) begin
        frame_log[frame_no % 8][acc_cnt] = pix_data;
        void'(exp_q.pop_front());
        acc_cnt++;
        if (last) begin
          acc_cnt = 0;
          if (auto_restart) begin
            buildFrame(ovl_en, ovl_x, ovl_y);
            frame_no++;
            exp_rise = cyc + 3;
          end else begin
            m_idle = 1'b1;
          end
        end else begin
          exp_rise = cyc + 3;
        end
      end
      if (idle_before && frame_start) begin
        buildFrame(ovl_en, ovl_x, ovl_y);
        frame_no++;
        m_idle = 1'b0;
        acc_cnt = 0;
        exp_rise = cyc + 3;
      end
      prev_rst = 1'b0;
    end
    prev_valid = pix_valid && !rst;
    prev_accept = acc;
    prev_data = pix_data;
  end

  task automatic startFrame();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic waitIdle(input int max_cycles, input bit rand_ready);
    int n;
    n = 0;
    while (!m_idle && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
      if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
    end
    checkOutput("frame_completes_in_budget", m_idle, 1);
    pix_ready = 1'b1;
  endtask

  // Waits until pixel k of model frame f is on the bus.
  task automatic waitPixel(input int f, input int k);
    int n;
    n = 0;
    while (!(frame_no == f && acc_cnt >= k && pix_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("pixel_reached_in_budget", (frame_no == f && acc_cnt >= k), 1);
  endtask

  initial begin
    int f, f0, fd0;
    #200000;
    $display("[TB] FAIL watchdog: simulation ran past its time budget");
    $fatal(1);
  end

  initial begin
    int f, f0, fd0;
    for (int i = 0; i < 8; i++) spr_mem[i] = 16'hAAAA;
    applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pix_data", pix_data, 0);
    checkOutput("reset_base_addr", base_addr, 0);
    checkOutput("reset_spr_addr", spr_addr, 0);
    checkOutput("reset_pix_valid", pix_valid, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_busy", busy, 0);
    rst = 1'b0;

    // Plain frame, no overlays
    $display("[TB] plain frame");
    fd0 = fd_cnt;
    startFrame();
    f = frame_no;
    waitIdle(200, 1'b0);
    checkOutput("plain_px0", frame_log[f % 8][0], 16'h0000);
    checkOutput("plain_px9", frame_log[f % 8][9], 16'h0009);
    checkOutput("plain_px15", frame_log[f % 8][15], 16'h000F);
    checkOutput("plain_frame_done_count", fd_cnt - fd0, 1);
    checkOutput("plain_busy_after", busy, 0);

    // Overlay 0 at (1,1) with a transparent bottom-right texel
    $display("[TB] single overlay with colour key");
    for (int i = 0; i < 4; i++) spr_mem[i] = 16'hAAAA;
    spr_mem[3] = TRANSP;
    for (int i = 4; i < 8; i++) spr_mem[i] = 16'h5555;
    applyStimulus(1'b0, 2'b01, 4'b0001, 4'b0001);
    startFrame();
    f = frame_no;
    waitIdle(200, 1'b0);
    checkOutput("key_px5", frame_log[f % 8][5], 16'hAAAA);
    checkOutput("key_px6", frame_log[f % 8][6], 16'hAAAA);
    checkOutput("key_px9", frame_log[f % 8][9], 16'hAAAA);
    checkOutput("key_px10", frame_log[f % 8][10], 16'h000A);
    checkOutput("key_px0", frame_log[f % 8][0], 16'h0000);

    // Both overlays at (0,0): overlay 0 wins, its key shows base not overlay 1
    $display("[TB] priority");
    applyStimulus(1'b0, 2'b11, 4'b0000, 4'b0000);
    startFrame();
    f = frame_no;
    waitIdle(200, 1'b0);
    checkOutput("prio_px0", frame_log[f % 8][0], 16'hAAAA);
    checkOutput("prio_px4", frame_log[f % 8][4], 16'hAAAA);
    checkOutput("prio_px5", frame_log[f % 8][5], 16'h0005);

    // Overlay at the bottom-right corner must clip, not wrap
    $display("[TB] corner clipping");
    applyStimulus(1'b0, 2'b01, 4'b0011, 4'b0011);
    startFrame();
    f = frame_no;
    waitIdle(200, 1'b0);
    checkOutput("clip_px15", frame_log[f % 8][15], 16'hAAAA);
    checkOutput("clip_px12", frame_log[f % 8][12], 16'h000C);
    checkOutput("clip_px3", frame_log[f % 8][3], 16'h0003);
    checkOutput("clip_px0", frame_log[f % 8][0], 16'h0000);

    // Back-pressure on pixel 6
    $display("[TB] back-pressure");
    applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
    startFrame();
    f = frame_no;
    waitPixel(f, 6);
    pix_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    pix_ready = 1'b1;
    waitIdle(200, 1'b0);
    checkOutput("stall_px6", frame_log[f % 8][6], 16'h0006);
    checkOutput("stall_px7", frame_log[f % 8][7], 16'h0007);

    // Auto restart with a sprite move mid-frame
    $display("[TB] auto restart");
    for (int i = 0; i < 4; i++) spr_mem[i] = 16'hAAAA;
    applyStimulus(1'b1, 2'b01, 4'b0000, 4'b0000);
    fd0 = fd_cnt;
    startFrame();
    f0 = frame_no;
    waitPixel(f0, 8);
    ovl_x = 4'b0010;
    waitPixel(f0 + 1, 0);
    auto_restart = 1'b0;
    waitIdle(300, 1'b0);
    checkOutput("auto_f1_px0", frame_log[f0 % 8][0], 16'hAAAA);
    checkOutput("auto_f1_px2", frame_log[f0 % 8][2], 16'h0002);
    checkOutput("auto_f2_px0", frame_log[(f0 + 1) % 8][0], 16'h0000);
    checkOutput("auto_f2_px2", frame_log[(f0 + 1) % 8][2], 16'hAAAA);
    checkOutput("auto_frame_done_count", fd_cnt - fd0, 2);

    // Reset in the middle of a frame
    $display("[TB] mid-frame reset");
    applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
    fd0 = fd_cnt;
    startFrame();
    f = frame_no;
    waitPixel(f, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_pix_valid", pix_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_no_frame_done", fd_cnt - fd0, 0);
    startFrame();
    f = frame_no;
    waitIdle(200, 1'b0);
    checkOutput("restart_px0", frame_log[f % 8][0], 16'h0000);
    checkOutput("restart_px9", frame_log[f % 8][9], 16'h0009);
    checkOutput("restart_frame_done_count", fd_cnt - fd0, 1);

    // Randomised sprites, positions and back-pressure
    $display("[TB] random frames");
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++)
        spr_mem[i] = ($urandom_range(0, 3) == 0) ? TRANSP : 16'($urandom);
      applyStimulus(1'b0, 2'($urandom), 4'($urandom), 4'($urandom));
      startFrame();
      waitIdle(600, 1'b1);
    end

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
